risc_intc: RTL and testbench

Interrupt controller and interval timer sitting directly upstream of the RiSC CPU core's interrupt input. It synchronises external interrupt lines, latches them as pending, and applies a mask and a fixed priority. It presents one vectored request at a time to the CPU through a req/ack/done handshake. Its registers are reached through the CPU's control-register write/read path.

---
 rtl/risc_intc.sv | 188 ++++++++++++++++++
 tb/tb_risc_intc.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_intc.sv
// risc_intc: interrupt controller and interval timer for the RiSC core.
// It synchronises the irq_in lines and latches them as pending. A mask, a global
// enable and a fixed lowest-index-wins priority select one source, which is then
// presented to the CPU through a req/ack/done handshake.
// Optional feature: define RISC_INTC_TIMER_EN to replace source 0 with an internal
// interval timer (PERIOD/COUNT registers). Without it PERIOD/COUNT read as 0.
module risc_intc #(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               cr_we,
  input  logic [2:0]         cr_addr,
  input  logic [15:0]        cr_wdata,
  output logic [15:0]        cr_rdata,
  output logic               int_req,
  output logic [2:0]         int_vec,
  input  logic               int_ack,
  input  logic               int_done
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } state_e;

  localparam logic [2:0] AddrPend   = 3'd0;
  localparam logic [2:0] AddrMask   = 3'd1;
  localparam logic [2:0] AddrCtrl   = 3'd2;
  localparam logic [2:0] AddrPeriod = 3'd3;
  localparam logic [2:0] AddrCount  = 3'd4;
  localparam logic [2:0] AddrStat   = 3'd5;

  state_e             state_q, state_d;
  logic [2:0]         vec_q, vec_d;
  logic [NUM_IRQ-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d, mask_q;
  logic               gie_q;
  logic [NUM_IRQ-1:0] irq_edge, set_ev, wr_clr, ack_clr, elig;
  logic [2:0]         win;
  logic               any_elig;
  logic               wr_pend, wr_mask, wr_ctrl;
  logic               unused_wdata;

  assign wr_pend = cr_we && (cr_addr == AddrPend);
  assign wr_mask = cr_we && (cr_addr == AddrMask);
  assign wr_ctrl = cr_we && (cr_addr == AddrCtrl);

  // Upper write-data bits have no destination for narrow configurations.
  assign unused_wdata = ^cr_wdata;

  // Two-flop synchroniser followed by a previous-value register for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign irq_edge = sync2_q & ~sync3_q;

`ifdef RISC_INTC_TIMER_EN
  logic [15:0] period_q, count_q;
  logic        wr_period, tmr_evt;

  assign wr_period = cr_we && (cr_addr == AddrPeriod);
  // Event on the edge where COUNT leaves 1 and reloads from PERIOD.
  assign tmr_evt   = (period_q != 16'd0) && (count_q == 16'd1);

  // Period register and down-counter; a period write restarts the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q <= '0;
      count_q  <= '0;
    end else if (wr_period) begin
      period_q <= cr_wdata;
      count_q  <= cr_wdata;
    end else if (period_q == 16'd0) begin
      count_q <= '0;
    end else if (count_q <= 16'd1) begin
      count_q <= period_q;
    end else begin
      count_q <= count_q - 16'd1;
    end
  end
`endif

  // Pending-set sources; the timer takes over source 0 when enabled
  always_comb begin
    set_ev = irq_edge;
`ifdef RISC_INTC_TIMER_EN
    set_ev[0] = tmr_evt;
`endif
  end

  // Clear events: W1C write and acknowledge of the in-flight vector
  always_comb begin
    wr_clr = wr_pend ? cr_wdata[NUM_IRQ-1:0] : '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_clr[i] = (state_q == StReq) && int_ack && (vec_q == 3'(i));
    end
  end

  // Set dominates clear on the same bit in the same cycle.
  assign pend_d = (pend_q & ~(wr_clr | ack_clr)) | set_ev;

  // Pending, mask and global-enable registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      mask_q <= '0;
      gie_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (wr_mask) mask_q <= cr_wdata[NUM_IRQ-1:0];
      if (wr_ctrl) gie_q  <= cr_wdata[0];
    end
  end

  // Fixed priority: scan downwards so the lowest eligible index is the last to win
  always_comb begin
    elig     = pend_q & mask_q;
    any_elig = |elig;
    win      = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) win = 3'(i);
    end
  end

  // FSM state and latched vector registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      vec_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  // FSM next state; the vector is captured only when leaving IDLE
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    unique case (state_q)
      StIdle: begin
        if (gie_q && any_elig) begin
          state_d = StReq;
          vec_d   = win;
        end
      end
      StReq: begin
        if (int_ack) state_d = StService;
      end
      StService: begin
        if (int_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign int_req = (state_q == StReq);
  assign int_vec = vec_q;

  // Register read mux, zero latency
  always_comb begin
    cr_rdata = '0;
    case (cr_addr)
      AddrPend: cr_rdata[NUM_IRQ-1:0] = pend_q;
      AddrMask: cr_rdata[NUM_IRQ-1:0] = mask_q;
      AddrCtrl: cr_rdata[0]           = gie_q;
`ifdef RISC_INTC_TIMER_EN
      AddrPeriod: cr_rdata = period_q;
      AddrCount:  cr_rdata = count_q;
`endif
      AddrStat: cr_rdata[5:0] = {state_q, 1'b0, vec_q};
      default:  cr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_risc_intc.sv
// Bench for risc_intc: directed stimulus, a cycle-level behavioural model checked
// on every falling edge, and hand-computed literal checks at key points.
module tb_risc_intc;

  logic        clk;
  logic        reset;
  logic [7:0]  irq_in;
  logic        cr_we;
  logic [2:0]  cr_addr;
  logic [15:0] cr_wdata;
  logic [15:0] cr_rdata;
  logic        int_req;
  logic [2:0]  int_vec;
  logic        int_ack;
  logic        int_done;

  int n_checks = 0;
  int n_fail   = 0;

  risc_intc #(.NUM_IRQ(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_in   (irq_in),
    .cr_we    (cr_we),
    .cr_addr  (cr_addr),
    .cr_wdata (cr_wdata),
    .cr_rdata (cr_rdata),
    .int_req  (int_req),
    .int_vec  (int_vec),
    .int_ack  (int_ack),
    .int_done (int_done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state after the most recent rising edge.
  logic [7:0]  m_pend, m_mask;
  logic        m_gie;
  int          m_state;            // 0 idle, 1 request, 2 service
  logic [2:0]  m_vec;
  logic [7:0]  p1, p2, p3;         // irq_in as sampled at the last three edges
  logic [15:0] m_period, m_count;

  function automatic logic [2:0] lowest(input logic [7:0] e);
    for (int i = 0; i < 8; i++) if (e[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {8'h00, m_pend};
      3'd1: return {8'h00, m_mask};
      3'd2: return {15'h0, m_gie};
`ifdef RISC_INTC_TIMER_EN
      3'd3: return m_period;
      3'd4: return m_count;
`endif
      3'd5: return {10'h0, 2'(m_state), 1'b0, m_vec};
      default: return 16'h0;
    endcase
  endfunction

  // Compare DUT against model, then advance the model by one edge
  always @(negedge clk) begin
    logic [7:0] set, clr;
    if (reset) begin
      m_pend = 0; m_mask = 0; m_gie = 0; m_state = 0; m_vec = 0;
      p1 = 0; p2 = 0; p3 = 0; m_period = 0; m_count = 0;
    end else begin
      check("model_int_req", 16'(int_req), 16'(m_state == 1));
      if (m_state == 1) check("model_int_vec", 16'(int_vec), 16'(m_vec));
      check("model_cr_rdata", cr_rdata, m_read(cr_addr));

      // An edge becomes pending three edges after irq_in is first sampled high.
      set = p2 & ~p3;
`ifdef RISC_INTC_TIMER_EN
      set[0] = (m_period != 0) && (m_count == 1);
`endif
      clr = (cr_we && cr_addr == 3'd0) ? cr_wdata[7:0] : 8'h00;
      if (m_state == 1 && int_ack) clr[m_vec] = 1'b1;

      case (m_state)
        0: if (m_gie && (m_pend & m_mask) != 0) begin
             m_vec   = lowest(m_pend & m_mask);
             m_state = 1;
           end
        1: if (int_ack) m_state = 2;
        2: if (int_done) m_state = 0;
        default: m_state = 0;
      endcase

      m_pend = (m_pend & ~clr) | set;
      if (cr_we && cr_addr == 3'd1) m_mask = cr_wdata[7:0];
      if (cr_we && cr_addr == 3'd2) m_gie = cr_wdata[0];
`ifdef RISC_INTC_TIMER_EN
      if (cr_we && cr_addr == 3'd3) begin
        m_period = cr_wdata;
        m_count  = cr_wdata;
      end else if (m_period == 0) m_count = 0;
      else if (m_count == 1) m_count = m_period;
      else m_count = m_count - 1;
`endif
      p3 = p2; p2 = p1; p1 = irq_in;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cr_we = 1'b1; cr_addr = a; cr_wdata = d;
    cyc(1);
    cr_we = 1'b0; cr_wdata = 16'h0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
    cr_addr = a;
    #1;
    check(name, cr_rdata, exp);
  endtask

  task automatic pulse_irq(input logic [7:0] b);
    irq_in = b;
    cyc(1);
    irq_in = 8'h00;
  endtask

  task automatic ack();
    int_ack = 1'b1; cyc(1); int_ack = 1'b0;
  endtask

  task automatic done();
    int_done = 1'b1; cyc(1); int_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_in = 0; cr_we = 0; cr_addr = 0; cr_wdata = 0;
    int_ack = 0; int_done = 0;
    cyc(2);
    reset = 1'b0;
    check("rst_req", 16'(int_req), 16'd0);
    rd(3'd5, 16'h0000, "rst_stat");
    rd(3'd1, 16'h0000, "rst_mask");

    // Single source, full handshake
    wr(3'd1, 16'h00FF);
    wr(3'd2, 16'h0001);
    rd(3'd2, 16'h0001, "gie_set");
    pulse_irq(8'h20);
    cyc(2);
    rd(3'd0, 16'h0020, "pend5_visible");
    check("req_not_yet", 16'(int_req), 16'd0);
    cyc(1);
    check("req5", 16'(int_req), 16'd1);
    check("vec5", 16'(int_vec), 16'd5);
    ack();
    check("req_after_ack", 16'(int_req), 16'd0);
    rd(3'd0, 16'h0000, "pend5_cleared");
    rd(3'd5, 16'h0025, "stat_service");
    done();
    rd(3'd5, 16'h0005, "stat_idle");

    // Two sources at once: lowest index first
    pulse_irq(8'h48);
    cyc(2);
    rd(3'd0, 16'h0048, "pend36");
    cyc(1);
    check("vec3_first", 16'(int_vec), 16'd3);
    ack();
    rd(3'd0, 16'h0040, "pend6_left");
    done();
    cyc(1);
    check("req6", 16'(int_req), 16'd1);
    check("vec6_second", 16'(int_vec), 16'd6);
    ack();
    done();

    // Masked source stays pending until unmasked
    wr(3'd1, 16'h0000);
    pulse_irq(8'h04);
    cyc(2);
    rd(3'd0, 16'h0004, "pend2_masked");
    cyc(2);
    check("masked_no_req", 16'(int_req), 16'd0);
    wr(3'd1, 16'h0004);
    check("unmask_same_cycle", 16'(int_req), 16'd0);
    cyc(1);
    check("unmask_req", 16'(int_req), 16'd1);
    check("unmask_vec2", 16'(int_vec), 16'd2);
    ack();
    done();

    // W1C on the same edge as a set: set wins
    pulse_irq(8'h02);
    cyc(1);
    wr(3'd0, 16'h0002);
    rd(3'd0, 16'h0002, "set_wins");
    wr(3'd0, 16'h0002);
    rd(3'd0, 16'h0000, "w1c");

    // Clearing GIE in REQ keeps the request
    wr(3'd1, 16'h00FF);
    pulse_irq(8'h80);
    cyc(3);
    check("req7", 16'(int_req), 16'd1);
    wr(3'd2, 16'h0000);
    check("gie_clr_req_held", 16'(int_req), 16'd1);
    check("gie_clr_vec_held", 16'(int_vec), 16'd7);
    ack();
    done();

    // GIE off: no request; a second edge while pending is lost
    pulse_irq(8'h02);
    cyc(2);
    rd(3'd0, 16'h0002, "pend1_gie_off");
    cyc(2);
    check("gie_off_no_req", 16'(int_req), 16'd0);
    pulse_irq(8'h02);
    cyc(2);
    wr(3'd2, 16'h0001);
    cyc(1);
    check("req1", 16'(int_vec), 16'd1);
    ack();
    rd(3'd0, 16'h0000, "edge_lost");
    done();

    // Reset in the middle of a request
    pulse_irq(8'h02);
    cyc(3);
    check("req_before_rst", 16'(int_req), 16'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_req", 16'(int_req), 16'd0);
    check("rst_mid_vec", 16'(int_vec), 16'd0);
    rd(3'd0, 16'h0000, "rst_mid_pend");
    rd(3'd5, 16'h0000, "rst_mid_stat");
    cyc(1);
    reset = 1'b0;

`ifdef RISC_INTC_TIMER_EN
    wr(3'd1, 16'h0001);
    wr(3'd3, 16'h0004);
    rd(3'd4, 16'h0004, "count4");
    cyc(1);
    rd(3'd4, 16'h0003, "count3");
    cyc(1);
    rd(3'd4, 16'h0002, "count2");
    cyc(1);
    rd(3'd4, 16'h0001, "count1");
    rd(3'd0, 16'h0000, "tmr_not_yet");
    cyc(1);
    rd(3'd4, 16'h0004, "count_reload");
    rd(3'd0, 16'h0001, "tmr_event");
    rd(3'd3, 16'h0004, "period_rd");
    wr(3'd3, 16'h0000);
    rd(3'd4, 16'h0000, "count_stopped");
    cyc(3);
    rd(3'd4, 16'h0000, "count_held");
`else
    wr(3'd3, 16'h0004);
    rd(3'd3, 16'h0000, "period_absent");
    rd(3'd4, 16'h0000, "count_absent");
    cyc(6);
    rd(3'd0, 16'h0000, "no_tmr_event");
`endif

    // Reserved addresses and CTRL upper bits
    wr(3'd6, 16'hFFFF);
    rd(3'd6, 16'h0000, "rsvd6");
    rd(3'd7, 16'h0000, "rsvd7");
    wr(3'd2, 16'hFFFF);
    rd(3'd2, 16'h0001, "ctrl_bits");
    cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
